// File: rtl/mul_eval_pkg.sv
// Shared types and helpers for the approximate-multiplier sweep controller.
package mul_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_IN_W  = 4;
    localparam int DEF_OUT_W = 4;

    function automatic logic [DEF_OUT_W-1:0] abs_diff(
        input logic [DEF_OUT_W-1:0] x,
        input logic [DEF_OUT_W-1:0] y
    );
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/mul_i4_o4_et_sweep_ctrl_exact.sv
// Exact reference product: low half of the vector times high half.
module mul_exact_ref #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4
) (
    input  logic [IN_W-1:0]  vec_i,
    output logic [OUT_W-1:0] prod_o
);

    localparam int HW = IN_W / 2;

    logic [HW-1:0]   a;
    logic [HW-1:0]   b;
    logic [IN_W-1:0] prod;

    assign a      = vec_i[HW-1:0];
    assign b      = vec_i[IN_W-1:HW];
    assign prod   = IN_W'(a) * IN_W'(b);
    assign prod_o = OUT_W'(prod);

endmodule

// File: rtl/mul_i4_o4_et_sweep_ctrl.sv
// Exhaustive sweep of an approximate multiplier netlist with error accumulation.
module mul_i4_o4_et_sweep_ctrl
    import mul_eval_pkg::*;
#(
    parameter int IN_W         = DEF_IN_W,
    parameter int OUT_W        = DEF_OUT_W,
    parameter int ET           = 8,
    parameter int PIPE_LAT     = 0,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [IN_W-1:0]       dut_in,
    input  logic [OUT_W-1:0]      dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [OUT_W-1:0]      max_err,
    output logic [IN_W-1:0]       worst_vec,
    output logic [IN_W+OUT_W-1:0] err_sum,
    output logic [IN_W:0]         fail_cnt
);

    localparam logic [3:0] DRAIN_LEN = 4'(PIPE_LAT + 1);

    state_e state_q, state_d;
    logic [IN_W-1:0] cnt_q, cnt_d;
    logic [3:0]      dcnt_q, dcnt_d;

    logic issue, running, accept;
    logic [IN_W-1:0]  tap_vec;
    logic             tap_vld;
    logic [OUT_W-1:0] exact;

    logic             cmp_vld_q;
    logic [IN_W-1:0]  cmp_vec_q;
    logic [OUT_W-1:0] cmp_err_q;
    logic             acc_en, fail_hit;

    logic [OUT_W-1:0]      max_q, max_d;
    logic [IN_W-1:0]       worst_q, worst_d;
    logic [IN_W+OUT_W-1:0] sum_q, sum_d;
    logic [IN_W:0]         fail_q, fail_d;
    logic                  pass_q, pass_d;

    assign issue   = (state_q == ISSUE);
    assign running = (state_q == ISSUE) || (state_q == DRAIN);
    assign accept  = (state_q == IDLE) && start && !abort;
    assign dut_in  = issue ? cnt_q : '0;

    // Delay line aligns each issued vector with its datapath response
    if (PIPE_LAT == 0) begin : g_nolat
        assign tap_vec = dut_in;
        assign tap_vld = issue;
    end else begin : g_lat
        logic [IN_W-1:0]     vec_q [PIPE_LAT];
        logic [PIPE_LAT-1:0] vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < PIPE_LAT; i++) vec_q[i] <= '0;
                vld_q <= '0;
            end else if (accept) begin
                for (int i = 0; i < PIPE_LAT; i++) vec_q[i] <= '0;
                vld_q <= '0;
            end else begin
                vec_q[0] <= dut_in;
                vld_q[0] <= issue;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    vec_q[i] <= vec_q[i-1];
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        assign tap_vec = vec_q[PIPE_LAT-1];
        assign tap_vld = vld_q[PIPE_LAT-1];
    end

    mul_exact_ref #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ref (
        .vec_i  (tap_vec),
        .prod_o (exact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld_q <= 1'b0;
            cmp_vec_q <= '0;
            cmp_err_q <= '0;
        end else if (accept) begin
            cmp_vld_q <= 1'b0;
            cmp_vec_q <= '0;
            cmp_err_q <= '0;
        end else begin
            cmp_vld_q <= tap_vld;
            cmp_vec_q <= tap_vec;
            cmp_err_q <= abs_diff(exact, dut_out);
        end
    end

    // Compares arriving after an early stop or abort are dropped
    assign acc_en   = cmp_vld_q && running && !abort;
    assign fail_hit = acc_en && (int'(cmp_err_q) > ET);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + IN_W'(1);
                if (cnt_q == '1) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                if (dcnt_q == DRAIN_LEN) state_d = DONE;
                else dcnt_d = dcnt_q + 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (STOP_ON_FAIL && fail_hit) state_d = DONE;
        if (abort) state_d = IDLE;
    end

    always_comb begin
        max_d   = max_q;
        worst_d = worst_q;
        sum_d   = sum_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        if (accept) begin
            max_d   = '0;
            worst_d = '0;
            sum_d   = '0;
            fail_d  = '0;
            pass_d  = 1'b0;
        end else if (acc_en) begin
            if (cmp_err_q > max_q) begin
                max_d   = cmp_err_q;
                worst_d = cmp_vec_q;
            end
            sum_d = sum_q + {{IN_W{1'b0}}, cmp_err_q};
            if (fail_hit) fail_d = fail_q + (IN_W+1)'(1);
        end
        if (abort) pass_d = 1'b0;
        else if (state_d == DONE && state_q != DONE) pass_d = (fail_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            max_q   <= '0;
            worst_q <= '0;
            sum_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            max_q   <= max_d;
            worst_q <= worst_d;
            sum_q   <= sum_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = running;
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign max_err   = max_q;
    assign worst_vec = worst_q;
    assign err_sum   = sum_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_mul_i4_o4_et_sweep_ctrl.sv
// Directed bench: four controller configurations against fixed datapaths.
module tb_mul_i4_o4_et_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_n, start, abort;

    always #5 clk = ~clk;

    logic [3:0] dut_in0, dut_in1, dut_in2, dut_in3;
    logic [3:0] dut_out2;
    logic busy0, busy1, busy2, busy3;
    logic done0, done1, done2, done3;
    logic pass0, pass1, pass2, pass3;
    logic [3:0] max0, max1, max2, max3;
    logic [3:0] wv0, wv1, wv2, wv3;
    logic [7:0] sum0, sum1, sum2, sum3;
    logic [4:0] fc0, fc1, fc2, fc3;

    // Exact 2x2 multiplier with two register stages
    logic [3:0] p1 = 4'd0;
    logic [3:0] p2 = 4'd0;
    always @(posedge clk) begin
        p1 <= {2'b00, dut_in2[1:0]} * {2'b00, dut_in2[3:2]};
        p2 <= p1;
    end
    assign dut_out2 = p2;

    mul_i4_o4_et_sweep_ctrl #(.ET(8), .PIPE_LAT(0), .STOP_ON_FAIL(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in0), .dut_out(4'b0111), .busy(busy0), .done(done0),
        .pass(pass0), .max_err(max0), .worst_vec(wv0), .err_sum(sum0),
        .fail_cnt(fc0));

    mul_i4_o4_et_sweep_ctrl #(.ET(6), .PIPE_LAT(0), .STOP_ON_FAIL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in1), .dut_out(4'b0111), .busy(busy1), .done(done1),
        .pass(pass1), .max_err(max1), .worst_vec(wv1), .err_sum(sum1),
        .fail_cnt(fc1));

    mul_i4_o4_et_sweep_ctrl #(.ET(8), .PIPE_LAT(2), .STOP_ON_FAIL(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in2), .dut_out(dut_out2), .busy(busy2), .done(done2),
        .pass(pass2), .max_err(max2), .worst_vec(wv2), .err_sum(sum2),
        .fail_cnt(fc2));

    mul_i4_o4_et_sweep_ctrl #(.ET(6), .PIPE_LAT(0), .STOP_ON_FAIL(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_in(dut_in3), .dut_out(4'b0111), .busy(busy3), .done(done3),
        .pass(pass3), .max_err(max3), .worst_vec(wv3), .err_sum(sum3),
        .fail_cnt(fc3));

    int total = 0;
    int bad   = 0;
    int nd0, nd2, nd3, hi0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Pulse start, then watch up to 30 cycles for done on each instance
    task automatic sweep();
        nd0 = -1;
        nd2 = -1;
        nd3 = -1;
        hi0 = 0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy0), 1);
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 5) chk("dut_in_issue", int'(dut_in0), 5);
            if (done0) begin
                hi0++;
                if (nd0 < 0) nd0 = n;
            end
            if (done2 && nd2 < 0) nd2 = n;
            if (done3 && nd3 < 0) nd3 = n;
        end
        chk("done_width", hi0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dut_in", int'(dut_in0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_sum", int'(sum0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep();
        chk("lat_p0", nd0, 18);
        chk("lat_p2", nd2, 20);
        chk("lat_stop", nd3, 2);
        chk("c7_max", int'(max0), 7);
        chk("c7_worst", int'(wv0), 0);
        chk("c7_sum", int'(sum0), 80);
        chk("c7_fail", int'(fc0), 0);
        chk("c7_pass", int'(pass0), 1);
        chk("et6_fail", int'(fc1), 7);
        chk("et6_pass", int'(pass1), 0);
        chk("et6_max", int'(max1), 7);
        chk("et6_worst", int'(wv1), 0);
        chk("ex_max", int'(max2), 0);
        chk("ex_sum", int'(sum2), 0);
        chk("ex_pass", int'(pass2), 1);
        chk("stop_fail", int'(fc3), 1);
        chk("stop_sum", int'(sum3), 7);
        chk("stop_pass", int'(pass3), 0);

        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_pass", int'(pass0), 0);
        hi0 = 0;
        repeat (25) begin
            if (done0) hi0++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_no_done", hi0, 0);

        sweep();
        chk("re_lat", nd0, 18);
        chk("re_sum", int'(sum0), 80);
        chk("re_pass", int'(pass0), 1);
        chk("re_et6_fail", int'(fc1), 7);

        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (17) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy0), 0);
        chk("arst_done", int'(done0), 0);
        chk("arst_sum", int'(sum0), 0);
        chk("arst_max", int'(max0), 0);
        chk("arst_fail", int'(fc1), 0);
        chk("arst_pass", int'(pass0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sweep();
        chk("post_rst_lat", nd0, 18);
        chk("post_rst_sum", int'(sum0), 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
